// File: rtl/rgb_ctrl_pkg.sv
// Constants shared by the RGB display controller timing blocks.
package rgb_ctrl_pkg;
   localparam int MIN_DIV     = 2;
   localparam int RGB_DEF_DIV = 4;
endpackage

// File: rtl/clk_div_prog.sv
// Programmable divider: registered level plus rise/fall enables, period = o_div_cur cycles.
// cfg handshake holds ready low until the pending divisor applies at a wrap (or at once if idle).
module clk_div_prog
   import rgb_ctrl_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = RGB_DEF_DIV
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_cfg_valid,
   input  logic [CNT_W-1:0] i_cfg_div,
   output logic             o_cfg_ready,
   output logic             o_clk_div,
   output logic             o_ce_rise,
   output logic             o_ce_fall,
   output logic [CNT_W-1:0] o_div_cur
);

   localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] MIN_N = CNT_W'(MIN_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_cur_q, div_cur_d;
   logic [CNT_W-1:0] div_pend_q, div_pend_d;
   logic             pend_q, pend_d;
   logic             rdy_q, rdy_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             wrap;
   logic             xfer;
   logic [CNT_W-1:0] hi_start;

   always_comb begin
      wrap       = i_en && (cnt_q == div_cur_q - 1'b1);
      xfer       = i_cfg_valid && rdy_q;
      div_pend_d = div_pend_q;
      div_cur_d  = div_cur_q;
      pend_d     = pend_q;
      rdy_d      = rdy_q;

      // ready is only high while nothing is pending, so accept and apply never collide
      if (xfer) begin
         div_pend_d = (i_cfg_div < MIN_N) ? MIN_N : i_cfg_div;
         pend_d     = 1'b1;
         rdy_d      = 1'b0;
      end else if (pend_q && (wrap || !i_en)) begin
         div_cur_d = div_pend_q;
         pend_d    = 1'b0;
         rdy_d     = 1'b1;
      end

      if (!i_en || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // Outputs are derived from next-state so they line up with the count they describe
      hi_start = div_cur_d - (div_cur_d >> 1);
      clk_d    = i_en && (cnt_d >= hi_start);
      rise_d   = i_en && (cnt_d == hi_start);
      fall_d   = wrap;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q      <= '0;
         div_cur_q  <= DEF_N;
         div_pend_q <= DEF_N;
         pend_q     <= 1'b0;
         rdy_q      <= 1'b1;
         clk_q      <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_cur_q  <= div_cur_d;
         div_pend_q <= div_pend_d;
         pend_q     <= pend_d;
         rdy_q      <= rdy_d;
         clk_q      <= clk_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
      end
   end

   assign o_cfg_ready = rdy_q;
   assign o_clk_div   = clk_q;
   assign o_ce_rise   = rise_q;
   assign o_ce_fall   = fall_q;
   assign o_div_cur   = div_cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: per-cycle model comparison plus literal waveform checks.
module tb_clk_div_prog;

   logic       clk = 1'b0;
   logic       i_rst_n = 1'b1;
   logic       i_en = 1'b0;
   logic       i_cfg_valid = 1'b0;
   logic [7:0] i_cfg_div = 8'd0;
   logic       o_cfg_ready;
   logic       o_clk_div;
   logic       o_ce_rise;
   logic       o_ce_fall;
   logic [7:0] o_div_cur;

   int n_tests = 0;
   int n_fail  = 0;

   clk_div_prog #(.CNT_W(8), .DEF_DIV(4)) dut (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_en),
      .i_cfg_valid (i_cfg_valid),
      .i_cfg_div   (i_cfg_div),
      .o_cfg_ready (o_cfg_ready),
      .o_clk_div   (o_clk_div),
      .o_ce_rise   (o_ce_rise),
      .o_ce_fall   (o_ce_fall),
      .o_div_cur   (o_div_cur)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: position within the current period, active divisor, one pending slot.
   int m_pos  = 0;
   int m_n    = 4;
   int m_pv   = 4;
   bit m_pend = 1'b0;
   bit m_clk  = 1'b0;
   bit m_rise = 1'b0;
   bit m_fall = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge i_rst_n);
         if (!i_rst_n) begin
            m_pos = 0; m_n = 4; m_pv = 4; m_pend = 1'b0;
            m_clk = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
         end else begin
            bit wrapped;
            int n_old;
            n_old   = m_n;
            wrapped = i_en && (m_pos == n_old - 1);
            if (i_cfg_valid && !m_pend) begin
               m_pv   = (int'(i_cfg_div) < 2) ? 2 : int'(i_cfg_div);
               m_pend = 1'b1;
            end else if (m_pend && (wrapped || !i_en)) begin
               m_n    = m_pv;
               m_pend = 1'b0;
            end
            m_pos  = i_en ? (m_pos + 1) % n_old : 0;
            m_clk  = i_en && (m_pos >= m_n - m_n / 2);
            m_rise = i_en && (m_pos == m_n - m_n / 2);
            m_fall = wrapped;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cyc_clk_div", 32'(o_clk_div), 32'(m_clk));
         chk("cyc_ce_rise", 32'(o_ce_rise), 32'(m_rise));
         chk("cyc_ce_fall", 32'(o_ce_fall), 32'(m_fall));
         chk("cyc_ready",   32'(o_cfg_ready), 32'(!m_pend));
         chk("cyc_div_cur", 32'(o_div_cur), 32'(m_n));
      end
   end

   logic [15:0] pc, pr, pf, py;

   task automatic capture(input int n);
      pc = '0; pr = '0; pf = '0; py = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pc = {pc[14:0], o_clk_div};
         pr = {pr[14:0], o_ce_rise};
         pf = {pf[14:0], o_ce_fall};
         py = {py[14:0], o_cfg_ready};
      end
   endtask

   task automatic offer(input logic [7:0] d);
      @(posedge clk); #1; i_cfg_valid = 1'b1; i_cfg_div = d;
      @(posedge clk); #1; i_cfg_valid = 1'b0;
   endtask

   initial begin
      #1 i_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_clk_div", 32'(o_clk_div), 0);
      chk("rst_ready",   32'(o_cfg_ready), 1);
      chk("rst_div_cur", 32'(o_div_cur), 4);
      chk("rst_pulses",  32'({o_ce_rise, o_ce_fall}), 0);
      @(posedge clk); #1; i_rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Default N=4 from idle
      #1; i_en = 1'b1;
      capture(8);
      chk("n4_clk",  32'(pc[7:0]), 32'h33);
      chk("n4_rise", 32'(pr[7:0]), 32'h22);
      chk("n4_fall", 32'(pf[7:0]), 32'h08);

      // N=5 offered mid-period
      @(posedge clk); #1;
      offer(8'd5);
      @(negedge clk);
      chk("n5_ready_drop", 32'(o_cfg_ready), 0);
      chk("n5_still_old",  32'(o_div_cur), 4);
      capture(8);
      chk("n5_clk",   32'(pc[7:0]), 32'h8C);
      chk("n5_ready", 32'(py[7:0]), 32'h7F);
      chk("n5_rise",  32'(pr[7:0]), 32'h08);
      chk("n5_fall",  32'(pf[7:0]), 32'h42);
      chk("n5_div",   32'(o_div_cur), 5);

      // Clamping of 0 and 1
      offer(8'd0);
      @(negedge clk);
      chk("n0_ready_drop", 32'(o_cfg_ready), 0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("n0_clamped", 32'(o_div_cur), 2);
      capture(4);
      chk("n2_alternate", 32'(pc[3:0] == 4'b0101 || pc[3:0] == 4'b1010), 1);
      offer(8'd1);
      @(negedge clk);
      chk("n1_ready_drop", 32'(o_cfg_ready), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("n1_clamped", 32'(o_div_cur), 2);
      chk("n1_ready",   32'(o_cfg_ready), 1);

      // Back to N=4 while idle, then N=6 offered exactly in a wrap cycle
      @(posedge clk); #1; i_en = 1'b0; i_cfg_valid = 1'b1; i_cfg_div = 8'd4;
      @(posedge clk); #1; i_cfg_valid = 1'b0;
      @(posedge clk); #1; i_en = 1'b1;
      chk("idle_apply", 32'(o_div_cur), 4);
      repeat (3) @(posedge clk);
      #1; i_cfg_valid = 1'b1; i_cfg_div = 8'd6;
      @(posedge clk); #1; i_cfg_valid = 1'b0;
      capture(10);
      chk("wrap_clk",   32'(pc[9:0]), 32'h0C7);
      chk("wrap_ready", 32'(py[9:0]), 32'h03F);
      chk("wrap_div",   32'(o_div_cur), 6);

      // Disable during high phase with N=8 pending
      @(posedge clk); #1;
      offer(8'd8);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("dis_high", 32'(o_clk_div), 1);
      chk("dis_pend", 32'(o_cfg_ready), 0);
      @(posedge clk); #1; i_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("dis_clk_low", 32'(o_clk_div), 0);
      chk("dis_no_fall", 32'(o_ce_fall), 0);
      chk("dis_applied", 32'(o_div_cur), 8);
      chk("dis_ready",   32'(o_cfg_ready), 1);
      @(posedge clk); #1; i_en = 1'b1;
      capture(8);
      chk("n8_clk",  32'(pc[7:0]), 32'h0F);
      chk("n8_rise", 32'(pr[7:0]), 32'h08);
      chk("n8_fall", 32'(pf[7:0]), 32'h00);

      // Async reset with a divisor pending
      offer(8'd10);
      @(negedge clk);
      chk("ar_pend", 32'(o_cfg_ready), 0);
      #2 i_rst_n = 1'b0;
      #1;
      chk("ar_clk_div", 32'(o_clk_div), 0);
      chk("ar_ready",   32'(o_cfg_ready), 1);
      chk("ar_div_cur", 32'(o_div_cur), 4);
      chk("ar_pulses",  32'({o_ce_rise, o_ce_fall}), 0);
      repeat (2) @(posedge clk);
      #1; i_rst_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("ar_discarded", 32'(o_div_cur), 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable clock divider for the RGB display controller, successor to the fixed divide-by-4 generator. Produces a divided clock-like level `o_clk_div` plus single-cycle rise/fall clock-enable pulses, all from one system clock, with the divide ratio set by a `CNT_W`-bit value. The ratio can be changed at runtime through a valid/ready handshake; a new ratio takes effect only at a period boundary, so no runt phase is ever produced. Downstream pixel-timing logic uses the enables, not `o_clk_div`, as its clock qualifier.

## Interface
- `CNT_W`, 8: counter and divisor width; divisors up to 2^CNT_W-1.
- `DEF_DIV`, 4: divisor active after reset; must satisfy 2 ≤ DEF_DIV ≤ 2^CNT_W-1.

- `clk`  in  1  system clock; the only clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_en`  in  1  run enable; low holds the divider idle.
- `i_cfg_valid`  in  1  new divisor offered.
- `i_cfg_div`  in  CNT_W  offered divisor N.
- `o_cfg_ready`  out  1  divider can accept a divisor.
- `o_clk_div`  out  1  divided level output, registered.
- `o_ce_rise`  out  1  one-cycle pulse, first cycle `o_clk_div` is high.
- `o_ce_fall`  out  1  one-cycle pulse, first cycle `o_clk_div` is low after a high phase.
- `o_div_cur`  out  CNT_W  divisor currently in effect.

## Operation
- State: `cnt` (CNT_W), `div_cur`, `div_pend`, `pend` flag; all outputs registered.
- Reset values: `cnt`=0, `div_cur`=DEF_DIV, `pend`=0, `o_cfg_ready`=1, `o_clk_div`=0, `o_ce_rise`=0, `o_ce_fall`=0, `o_div_cur`=DEF_DIV.
- Counting (i_en=1): `cnt` wraps to 0 when `cnt`==N-1, else increments. N=`div_cur`.
- Duty: H=floor(N/2). `o_clk_div`=1 exactly when `cnt` ≥ N-H. Low phase is ceil(N/2) cycles, high phase floor(N/2) cycles. Odd N gives low-biased duty (N=5: 3 low, 2 high).
- `o_ce_rise`=1 in the cycle `cnt`==N-H. `o_ce_fall`=1 in the cycle `cnt`==0 immediately following a wrap. Neither pulses in other cycles.
- Disable (i_en=0, sampled synchronously): next cycle `cnt`=0, `o_clk_div`=0, no pulses, including when leaving a high phase. Re-enable resumes from `cnt`=0 as after reset.
- Config handshake: a transfer occurs when `i_cfg_valid` & `o_cfg_ready`. Values < 2 are clamped to 2. The value is stored in `div_pend`, `pend`←1 and `o_cfg_ready`←0 on the next edge. `i_cfg_valid` with ready low is ignored, not queued.
- Apply: when `pend`=1 and either (i_en=1 and `cnt`==`div_cur`-1) or i_en=0, then `div_cur`←`div_pend`, `pend`←0, `o_cfg_ready`←1, `o_div_cur` updates. The wrap cycle uses the new N from `cnt`=0 onward.
- A transfer accepted in a wrap cycle is not applied at that wrap; it is applied at the next one, because `pend` was 0 when the wrap was evaluated.
- Asynchronous reset mid-operation discards any pending divisor and restores DEF_DIV.

## Timing
- Period N cycles exactly; no clock gating or combinational paths from inputs to outputs.
- Handshake latency: `o_cfg_ready` drops 1 cycle after the transfer. It rises in the cycle the new N becomes active, at most N_old cycles after the transfer while enabled, or 1 cycle while disabled.
- `o_clk_div` and the enables are cycle-aligned: `o_ce_rise` coincides with the first high cycle, `o_ce_fall` with the first low cycle.

## Structure
- `rgb_ctrl_pkg` holds the constant `MIN_DIV`=2 and the default-divisor constant shared with the timing generator.
- Single module; no sub-module is warranted. Counter, duty compare and config register form one small datapath.

## Test plan
- Reset, i_en=1, DEF_DIV=4 -> `o_clk_div` pattern 0,0,1,1 repeating; `o_ce_rise` at cnt=2, `o_ce_fall` at cnt=0 after each wrap; period 4.
- Config N=5 mid-period -> ready low next cycle; current period completes with N=4; then pattern 0,0,0,1,1; ready high at the switch.
- Config N=0 and N=1 -> clamped; `o_div_cur`=2; output toggles every cycle with rise/fall pulses alternating.
- Transfer coincident with a wrap (N=6 while N=4) -> one further N=4 period, then N=6 (3 low, 3 high).
- i_en dropped during the high phase -> next cycle `o_clk_div`=0 with no `o_ce_fall`; pending N=8 applies after 1 cycle; re-enable gives 4 low, 4 high.
- Async reset asserted with `pend`=1 -> all outputs at reset values; `o_div_cur`=DEF_DIV; ready=1.
